seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display. It holds a 4-digit BCD value with decimal points and cycles through the digits. For each digit it drives one active-low anode plus the decoded active-low segment pattern, with a blanking guard interval between digits to prevent ghosting. New values are staged through a load/ack handshake and committed only at frame boundaries, so a frame never shows a mix of old and new digits. The block sits between game/score logic and the board display pins.

## Interface
- REFRESH_DIV, 100000: cycles each digit is driven (≈1 kHz/digit at 100 MHz); must be ≥1
- GUARD_CYCLES, 16: cycles all anodes are off before each digit; must be ≥1
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- enable  in  1  1 = scan display; 0 = display dark
- value_in  in  16  four BCD nibbles; [3:0] = digit 0 (rightmost, an[0])
- dp_in  in  4  decimal-point request per digit, active-high
- load  in  1  single-cycle strobe: stage value_in/dp_in
- lz_en  in  1  leading-zero suppression enable
- an  out  4  digit anodes, active-low, at most one low
- seg  out  7  segments, active-low, {g,f,e,d,c,b,a}
- dp  out  1  decimal point, active-low
- load_ack  out  1  one-cycle pulse when staged data becomes the displayed data

## Operation
- States: OFF, GUARD, DRIVE; digit index idx (0..3); phase counter cnt.
- Reset (rst_n=0 at an edge): state OFF, an=4'hF, seg=7'h7F, dp=1, load_ack=0, idx=0, cnt=0, shadow and staged registers 0, pending=0.
- OFF: an=F, seg=7F, dp=1. When enable=1, go to GUARD with idx=0 and cnt=0.
- GUARD: an=F, seg=7F, dp=1 for GUARD_CYCLES cycles, then DRIVE.
- DRIVE: an[idx]=0 and all other anodes 1; seg = decode(shadow nibble idx); dp = ~shadow_dp[idx]. Held for REFRESH_DIV cycles, then idx ← idx+1 mod 4 and go to GUARD.
- Frame boundary: the final DRIVE cycle with idx=3. If pending=1 there, shadow ← staged, pending ← 0, and load_ack pulses on the next cycle.
- load=1: staged ← {value_in, dp_in}, pending ← 1.
  - A load while already pending overwrites the staged data. Last load wins, and there is exactly one ack per commit.
- load in the same cycle as a frame-boundary commit: the commit uses the previously staged data. The new data is captured into staged and pending stays 1 for the next frame.
- load while in OFF: commits immediately. Shadow is updated and load_ack pulses on the following cycle.
- enable dropped in any state: the next state is OFF, with outputs dark, idx=0 and cnt=0. Pending and staged data are retained.
- Leading-zero suppression (lz_en=1): digit k∈{3,2,1} is blanked (seg=7F) if nibbles k..3 are all zero. Digit 0 is never suppressed, and dp is unaffected by suppression.
- Nibbles ≥10 display blank (seg=7F).
- Reset asserted mid-frame: all registers take reset values at that edge, and pending/staged data is lost.

## Timing
- All outputs are registered; an, seg and dp change together on the same edge as the state transition.
- Digit period is GUARD_CYCLES + REFRESH_DIV cycles; frame period is 4 × (GUARD_CYCLES + REFRESH_DIV).
- After enable rises in OFF: GUARD begins on the next edge, and an[0] goes low GUARD_CYCLES cycles later.
- Load-to-display latency:
  - While scanning: at most one frame plus 1 cycle.
  - In OFF: 1 cycle.
- load_ack is high for exactly one cycle per commit and is never high while rst_n=0.
- cnt width is $clog2(max(REFRESH_DIV, GUARD_CYCLES)+1). The counter saturates at its terminal count.

## Structure
- Package seg7_pkg holds:
  - the state enum (OFF, GUARD, DRIVE)
  - NUM_DIGITS=4
  - SEG_BLANK=7'h7F
  - AN_OFF=4'hF
- One sub-module instance: hexto7segment, the existing 4-bit to active-low 7-segment decoder, which blanks codes ≥10. It is fed the shadow nibble selected by idx. Its output is then masked by suppression and registered.

## Test plan
All scenarios use REFRESH_DIV=8 and GUARD_CYCLES=2.
- Reset state: hold rst_n=0 for 3 cycles → an=F, seg=7F, dp=1, load_ack=0. After release with enable=0, outputs stay dark.
- Load while OFF, then scan: load 16'h1234 with dp_in=4'b0100 while OFF → load_ack 1 cycle later. Then enable=1 → an sequence E,D,B,7, each low for 8 cycles after a 2-cycle dark guard, with seg = decode of 4,3,2,1. dp=0 only while an=B.
- Frame-boundary commit: load 16'h9999 during digit 1 of a frame showing 1234 → that frame finishes with 1234, the next frame shows 9999, and load_ack pulses once right after the idx=3 DRIVE ends.
- Back-to-back loads: load 16'h1111 then 16'h2222 in the same frame → only 2222 is displayed and exactly one ack. Also, a load coinciding with the boundary cycle is displayed one frame later with a second ack.
- Suppression: lz_en=1, value 16'h0050 → digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0. Value 16'h0000 → only digit 0 is lit, showing 0. Nibble A shows blank.
- Mid-operation control: drop enable during DRIVE of digit 2 → next cycle an=F and idx=0, and re-enable restarts at digit 0. Assert rst_n=0 mid-DRIVE with a load pending → reset values, no ack, and display 0000 after re-enable.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared types and constants for the seven-segment scan controller:
// scan state encoding, digit count, and the dark patterns for the
// active-low anode and segment buses.
package seg7_pkg;

    typedef enum logic [1:0] {
        OFF,
        GUARD,
        DRIVE
    } state_t;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;

    // True when digit k is a leading zero: k is not the rightmost digit
    // and nibbles k..3 of v are all zero.
    function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] k);
        logic [15:0] hi;
        hi = v >> {k, 2'b00};
        return (k != 2'd0) && (hi == 16'h0000);
    endfunction

endpackage

// File: rtl/hexto7segment.sv
// hexto7segment
// 4-bit code to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Codes 0-9 show the decimal digit; codes 10-15 are blanked.
// Ports:
//   hex  in  4  code to decode
//   seg  out 7  active-low segment pattern
module hexto7segment
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode display.
// Each digit gets a dark guard interval followed by a drive interval.
// New values are staged via load and committed to the displayed (shadow)
// copy only at a frame boundary, or immediately while the display is off.
// Ports:
//   clk       in  1   system clock
//   rst_n     in  1   synchronous active-low reset
//   enable    in  1   1 = scan, 0 = dark
//   value_in  in  16  four BCD nibbles, [3:0] = digit 0 (an[0])
//   dp_in     in  4   decimal-point request per digit, active-high
//   load      in  1   strobe: stage value_in/dp_in
//   lz_en     in  1   leading-zero suppression enable
//   an        out 4   digit anodes, active-low
//   seg       out 7   segments {g,f,e,d,c,b,a}, active-low
//   dp        out 1   decimal point, active-low
//   load_ack  out 1   one-cycle pulse when staged data is committed
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        load_ack
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);

    state_t          state;
    logic [1:0]      idx;
    logic [CW-1:0]   cnt;
    logic [15:0]     shadow_val;
    logic [3:0]      shadow_dp;
    logic [15:0]     staged_val;
    logic [3:0]      staged_dp;
    logic            pending;
    logic            ack_r;

    logic [3:0]      nib_sel;
    logic [6:0]      seg_dec;
    logic [6:0]      seg_drive;
    logic [3:0]      an_drive;

    assign nib_sel = shadow_val[{idx, 2'b00} +: 4];

    hexto7segment u_dec (
        .hex (nib_sel),
        .seg (seg_dec)
    );

    assign seg_drive = (lz_en && lz_blank(shadow_val, idx)) ? SEG_BLANK : seg_dec;
    assign an_drive  = ~(4'b0001 << idx);

    // Gate with rst_n so an ack registered just before reset cannot
    // appear while reset is being held.
    assign load_ack = ack_r & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= OFF;
            idx        <= 2'd0;
            cnt        <= '0;
            shadow_val <= 16'h0000;
            shadow_dp  <= 4'h0;
            staged_val <= 16'h0000;
            staged_dp  <= 4'h0;
            pending    <= 1'b0;
            ack_r      <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
        end else begin
            ack_r <= 1'b0;
            an    <= AN_OFF;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;

            // Staging always captures; commit below may still use the
            // previously staged value in this same cycle.
            if (load) begin
                staged_val <= value_in;
                staged_dp  <= dp_in;
                pending    <= 1'b1;
            end

            case (state)
                OFF: begin
                    // Nothing is on screen, so a load can commit at once.
                    if (load) begin
                        shadow_val <= value_in;
                        shadow_dp  <= dp_in;
                        pending    <= 1'b0;
                        ack_r      <= 1'b1;
                    end
                    idx <= 2'd0;
                    cnt <= '0;
                    if (enable) begin
                        state <= GUARD;
                    end
                end

                GUARD: begin
                    if (!enable) begin
                        state <= OFF;
                        idx   <= 2'd0;
                        cnt   <= '0;
                    end else if (cnt == GUARD_LAST) begin
                        state <= DRIVE;
                        cnt   <= '0;
                        an    <= an_drive;
                        seg   <= seg_drive;
                        dp    <= ~shadow_dp[idx];
                    end else if (cnt != CNT_SAT) begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DRIVE: begin
                    if (!enable) begin
                        state <= OFF;
                        idx   <= 2'd0;
                        cnt   <= '0;
                    end else if (cnt == DRIVE_LAST) begin
                        state <= GUARD;
                        cnt   <= '0;
                        idx   <= idx + 2'd1;
                        // Frame boundary: swap in staged data while dark.
                        if (idx == 2'd3 && pending) begin
                            shadow_val <= staged_val;
                            shadow_dp  <= staged_dp;
                            pending    <= load;
                            ack_r      <= 1'b1;
                        end
                    end else begin
                        if (cnt != CNT_SAT) begin
                            cnt <= cnt + 1'b1;
                        end
                        an  <= an_drive;
                        seg <= seg_drive;
                        dp  <= ~shadow_dp[idx];
                    end
                end

                default: begin
                    state <= OFF;
                    idx   <= 2'd0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
// Directed bench for seg7_scan_ctrl with REFRESH_DIV=8, GUARD_CYCLES=2.
// Expected digit patterns are queued when a value is loaded/expected to
// be on screen and popped as each digit's drive interval begins.
module tb_seg7_scan_ctrl;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        load_ack;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   ack_cnt = 0;
    exp_t exp_q[$];

    seg7_scan_ctrl #(
        .REFRESH_DIV  (8),
        .GUARD_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .value_in (value_in),
        .dp_in    (dp_in),
        .load     (load),
        .lz_en    (lz_en),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .load_ack (load_ack)
    );

    always #5 clk = ~clk;

    // Counts every cycle in which load_ack was high.
    always @(posedge clk) begin
        if (load_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within 500000 ns");
        $fatal(1);
    end

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic exp_t mk(input logic [15:0] v, input logic [3:0] d,
                                input logic lz, input int k);
        exp_t        e;
        logic [15:0] hi;
        e.an    = 4'hF;
        e.an[k] = 1'b0;
        hi      = v >> (4 * k);
        e.seg   = ref_seg(hi[3:0]);
        if (lz && k > 0 && hi == 16'h0000) e.seg = 7'h7F;
        e.dp    = ~d[k];
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_digit(input logic [15:0] v, input logic [3:0] d,
                              input logic lz, input int k);
        exp_q.push_back(mk(v, d, lz, k));
    endtask

    task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic lz);
        for (int k = 0; k < 4; k++) push_digit(v, d, lz, k);
    endtask

    // act: 0 = plain, 1 = load v/d at drive cycle 'at', 2 = drop enable at
    // first drive cycle, 3 = reset at first drive cycle.
    // Returns w = negedges waited in the dark before the digit lit.
    task automatic scan_digit(input int act, input int at, input logic [15:0] v,
                              input logic [3:0] d, output int w);
        exp_t       e;
        logic [3:0] a;
        int         n;
        w = 0;
        while (an === 4'hF && w < 64) begin
            tick();
            w++;
        end
        e = exp_q.pop_front();
        chk("digit", {20'h0, an, seg, dp}, {20'h0, e});
        if (act == 2) begin
            enable = 1'b0;
            tick();
            chk("en_drop_dark", {20'h0, an, seg, dp}, {20'h0, 4'hF, 7'h7F, 1'b1});
            return;
        end
        if (act == 3) begin
            rst_n = 1'b0;
            tick();
            chk("rst_mid_dark", {20'h0, an, seg, dp}, {20'h0, 4'hF, 7'h7F, 1'b1});
            chk("rst_mid_ack", {31'h0, load_ack}, 32'h0);
            tick();
            chk("rst_hold_ack", {31'h0, load_ack}, 32'h0);
            rst_n = 1'b1;
            return;
        end
        a = an;
        n = 1;
        forever begin
            if (act == 1 && n == at) begin
                value_in = v;
                dp_in    = d;
                load     = 1'b1;
            end
            tick();
            load = 1'b0;
            if (an !== a || n >= 64) break;
            n++;
        end
        chk("digit_len", n, 8);
    endtask

    task automatic scan_frame(input int w0);
        int w;
        for (int k = 0; k < 4; k++) begin
            scan_digit(0, 0, 16'h0, 4'h0, w);
            if (k == 0 && w0 >= 0) chk("enable_to_drive", w, w0);
            if (k > 0) chk("guard_len", w, 2);
        end
    endtask

    initial begin
        int w;
        int a;

        rst_n    = 1'b0;
        enable   = 1'b0;
        value_in = 16'h0;
        dp_in    = 4'h0;
        load     = 1'b0;
        lz_en    = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_an", {28'h0, an}, 32'hF);
        chk("rst_seg", {25'h0, seg}, 32'h7F);
        chk("rst_dp", {31'h0, dp}, 32'h1);
        chk("rst_ack", {31'h0, load_ack}, 32'h0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_dark", {20'h0, an, seg, dp}, {20'h0, 4'hF, 7'h7F, 1'b1});
        chk("idle_ack", {31'h0, load_ack}, 32'h0);

        // Load while OFF, then scan
        a = ack_cnt;
        value_in = 16'h1234;
        dp_in    = 4'b0100;
        load     = 1'b1;
        tick();
        load = 1'b0;
        chk("ack_off", {31'h0, load_ack}, 32'h1);
        tick();
        chk("ack_off_pulse", {31'h0, load_ack}, 32'h0);
        push_frame(16'h1234, 4'b0100, 1'b0);
        enable = 1'b1;
        scan_frame(3);
        chk("ack_none_f1", {31'h0, load_ack}, 32'h0);
        tick();
        chk("ack_cnt_off", ack_cnt - a, 1);

        // Frame-boundary commit
        a = ack_cnt;
        push_frame(16'h1234, 4'b0100, 1'b0);
        scan_digit(0, 0, 16'h0, 4'h0, w);
        scan_digit(1, 1, 16'h9999, 4'b0001, w);
        scan_digit(0, 0, 16'h0, 4'h0, w);
        scan_digit(0, 0, 16'h0, 4'h0, w);
        chk("ack_boundary", {31'h0, load_ack}, 32'h1);
        tick();
        chk("ack_boundary_pulse", {31'h0, load_ack}, 32'h0);
        push_frame(16'h9999, 4'b0001, 1'b0);
        scan_frame(-1);
        chk("ack_none_f3", {31'h0, load_ack}, 32'h0);
        tick();
        chk("ack_cnt_boundary", ack_cnt - a, 1);

        // Back-to-back loads in one frame
        a = ack_cnt;
        push_frame(16'h9999, 4'b0001, 1'b0);
        scan_digit(1, 1, 16'h1111, 4'h0, w);
        scan_digit(1, 1, 16'h2222, 4'h0, w);
        scan_digit(0, 0, 16'h0, 4'h0, w);
        scan_digit(0, 0, 16'h0, 4'h0, w);
        chk("ack_b2b", {31'h0, load_ack}, 32'h1);
        tick();
        chk("ack_cnt_b2b", ack_cnt - a, 1);

        // Load coinciding with the boundary while another load is pending
        a = ack_cnt;
        push_frame(16'h2222, 4'h0, 1'b0);
        scan_digit(0, 0, 16'h0, 4'h0, w);
        scan_digit(1, 1, 16'h4444, 4'hF, w);
        scan_digit(0, 0, 16'h0, 4'h0, w);
        scan_digit(1, 8, 16'h3333, 4'h0, w);
        chk("ack_edge_commit", {31'h0, load_ack}, 32'h1);
        tick();
        push_frame(16'h4444, 4'hF, 1'b0);
        scan_frame(-1);
        chk("ack_edge_second", {31'h0, load_ack}, 32'h1);
        tick();
        push_frame(16'h3333, 4'h0, 1'b0);
        scan_frame(-1);
        chk("ack_edge_none", {31'h0, load_ack}, 32'h0);
        tick();
        chk("ack_cnt_edge", ack_cnt - a, 2);

        // Drop enable during digit 2
        push_digit(16'h3333, 4'h0, 1'b0, 0);
        push_digit(16'h3333, 4'h0, 1'b0, 1);
        push_digit(16'h3333, 4'h0, 1'b0, 2);
        scan_digit(0, 0, 16'h0, 4'h0, w);
        scan_digit(0, 0, 16'h0, 4'h0, w);
        scan_digit(2, 0, 16'h0, 4'h0, w);

        // Leading-zero suppression, restart from digit 0
        value_in = 16'h0050;
        dp_in    = 4'b0100;
        load     = 1'b1;
        tick();
        load = 1'b0;
        chk("ack_off_lz", {31'h0, load_ack}, 32'h1);
        lz_en  = 1'b1;
        enable = 1'b1;
        push_frame(16'h0050, 4'b0100, 1'b1);
        scan_frame(3);

        enable = 1'b0;
        tick();
        value_in = 16'h0000;
        dp_in    = 4'h0;
        load     = 1'b1;
        tick();
        load   = 1'b0;
        enable = 1'b1;
        push_frame(16'h0000, 4'h0, 1'b1);
        scan_frame(3);

        enable = 1'b0;
        tick();
        value_in = 16'hA0B1;
        dp_in    = 4'b1000;
        load     = 1'b1;
        tick();
        load   = 1'b0;
        enable = 1'b1;
        push_digit(16'hA0B1, 4'b1000, 1'b1, 0);
        push_digit(16'hA0B1, 4'b1000, 1'b1, 1);
        push_digit(16'hA0B1, 4'b1000, 1'b1, 2);

        // Reset mid-DRIVE with a load pending
        scan_digit(0, 0, 16'h0, 4'h0, w);
        scan_digit(1, 1, 16'h7777, 4'hF, w);
        a = ack_cnt;
        scan_digit(3, 0, 16'h0, 4'h0, w);
        lz_en = 1'b0;
        push_frame(16'h0000, 4'h0, 1'b0);
        scan_frame(-1);
        chk("ack_after_rst", {31'h0, load_ack}, 32'h0);
        tick();
        push_frame(16'h0000, 4'h0, 1'b0);
        scan_frame(-1);
        chk("ack_after_rst2", {31'h0, load_ack}, 32'h0);
        tick();
        chk("ack_cnt_rst", ack_cnt - a, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
